// File: rtl/fifo_burst_sched_if.sv
// Handshake bundle between the burst scheduler, its source FIFO and the byte sink.
// master = scheduler side, slave = FIFO/sink environment side.
interface fifo_burst_sched_if #(
  parameter int pLEN_WIDTH = 16
);
  logic                  I_arm;
  logic                  I_burst_req;
  logic [pLEN_WIDTH-1:0] I_burst_len;
  logic                  I_fifo_empty;
  logic [17:0]           I_fifo_dout;
  logic [5:0]            I_fifo_status;
  logic                  O_fifo_rd_en;
  logic [7:0]            O_data;
  logic                  O_data_valid;
  logic                  I_data_ready;
  logic                  O_busy;
  logic                  O_flushing;
  logic                  O_burst_done;
  logic                  O_timeout;

  modport master (
    input  I_arm, I_burst_req, I_burst_len, I_fifo_empty, I_fifo_dout,
           I_fifo_status, I_data_ready,
    output O_fifo_rd_en, O_data, O_data_valid, O_busy, O_flushing,
           O_burst_done, O_timeout
  );

  modport slave (
    output I_arm, I_burst_req, I_burst_len, I_fifo_empty, I_fifo_dout,
           I_fifo_status, I_data_ready,
    input  O_fifo_rd_en, O_data, O_data_valid, O_busy, O_flushing,
           O_burst_done, O_timeout
  );
endinterface

// File: rtl/fifo_burst_sched.sv
// Streams bursts of 18-bit FIFO entries (plus 6 status bits) as 3 bytes each, with arm-triggered flush.
// Define PW_BURST_TIMEOUT_EN to end a burst that stalls on an empty FIFO for pTIMEOUT_CYCLES.
module fifo_burst_sched #(
  parameter int pLEN_WIDTH      = 16,
  parameter int pTIMEOUT_CYCLES = 1024
) (
  input logic                cwusb_clk,
  input logic                reset_i,
  fifo_burst_sched_if.master bus
);

  typedef enum logic [2:0] {IDLE, FLUSH, POP, LOAD, BYTE, DONE} state_t;

  localparam logic [pLEN_WIDTH-1:0] LEN_ONE = 1;

  state_t                state;
  logic [pLEN_WIDTH-1:0] remaining;
  logic [1:0]            byte_idx;
  logic [17:0]           hold_dout;
  logic [5:0]            hold_status;
  logic                  pop;
  logic                  stall_hit;
  logic [7:0]            data;

  if (pTIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("pTIMEOUT_CYCLES must be at least 1");
  end

  // The pop strobe follows I_fifo_empty in the same cycle, so it can never fire on an empty FIFO.
  assign pop = ((state == FLUSH) || (state == POP)) && !bus.I_fifo_empty;

  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    if (reset_i) begin
      state       <= IDLE;
      remaining   <= '0;
      byte_idx    <= '0;
      hold_dout   <= '0;
      hold_status <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.I_arm) begin
            state <= FLUSH;
          end else if (bus.I_burst_req) begin
            if (bus.I_burst_len == '0) begin
              state <= DONE;
            end else begin
              remaining <= bus.I_burst_len;
              state     <= POP;
            end
          end
        end
        FLUSH: begin
          if (bus.I_fifo_empty) state <= IDLE;
        end
        POP: begin
          if (bus.I_arm)       state <= FLUSH;
          else if (pop)        state <= LOAD;
          else if (stall_hit)  state <= DONE;
        end
        LOAD: begin
          if (bus.I_arm) begin
            state <= FLUSH;
          end else begin
            hold_dout   <= bus.I_fifo_dout;
            hold_status <= bus.I_fifo_status;
            byte_idx    <= 2'd0;
            state       <= BYTE;
          end
        end
        BYTE: begin
          if (bus.I_arm) begin
            state <= FLUSH;
          end else if (bus.I_data_ready) begin
            if (byte_idx == 2'd2) begin
              remaining <= remaining - LEN_ONE;
              byte_idx  <= 2'd0;
              state     <= (remaining == LEN_ONE) ? DONE : POP;
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        DONE: begin
          state <= bus.I_arm ? FLUSH : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PW_BURST_TIMEOUT_EN
  localparam int STALL_W = $clog2(pTIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall;
  logic               timeout_q;

  // Counts consecutive empty cycles spent in POP; any pop or state change restarts it.
  assign stall_hit = (state == POP) && bus.I_fifo_empty && !bus.I_arm &&
                     (stall == STALL_W'(pTIMEOUT_CYCLES - 1));

  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      stall     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if ((state == POP) && bus.I_fifo_empty && !bus.I_arm) stall <= stall + STALL_W'(1);
      else                                                   stall <= '0;
      if (bus.I_arm)      timeout_q <= 1'b0;
      else if (stall_hit) timeout_q <= 1'b1;
    end
  end

  assign bus.O_timeout = timeout_q;
`else
  assign stall_hit     = 1'b0;
  assign bus.O_timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: the default arm gives data a value on every path, so no latch is inferred.
    case (byte_idx)
      2'd0:    data = hold_dout[7:0];
      2'd1:    data = hold_dout[15:8];
      default: data = {hold_status, hold_dout[17:16]};
    endcase
  end

  assign bus.O_fifo_rd_en = pop;
  assign bus.O_data       = data;
  assign bus.O_data_valid = (state == BYTE);
  assign bus.O_busy       = (state != IDLE);
  assign bus.O_flushing   = (state == FLUSH);
  assign bus.O_burst_done = (state == DONE);

endmodule

// File: tb/tb_fifo_burst_sched.sv
// Randomized bench for fifo_burst_sched: FIFO model, byte scoreboard, directed corner cases.
// Timeout checks follow PW_BURST_TIMEOUT_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_fifo_burst_sched;
  localparam int LW = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_burst_sched_if #(.pLEN_WIDTH(LW)) bus ();

  fifo_burst_sched #(.pLEN_WIDTH(LW), .pTIMEOUT_CYCLES(TO)) dut (
    .cwusb_clk(clk),
    .reset_i  (rst),
    .bus      (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: entries written by the stimulus, popped on rd_en, data valid one cycle later.
  logic [17:0] mem [0:1023];
  int wr_idx = 0;
  int rd_idx = 0;

  assign bus.I_fifo_empty = (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (bus.O_fifo_rd_en && (rd_idx != wr_idx)) begin
      bus.I_fifo_dout <= mem[rd_idx];
      rd_idx          <= rd_idx + 1;
    end
  end

  // Monitor: drives ready, records accepted bytes and protocol observations each negedge.
  int         ready_mode = 0;  // 0 high, 1 toggle, 2 random, 3 low
  logic       tog = 1'b0;
  int         cyc = 0;
  logic [7:0] got_q[$];
  int pop_cnt = 0, flush_pop_cnt = 0, done_cnt = 0;
  int rd_empty_viol = 0, stable_viol = 0, abort_viol = 0;
  int last_pop_cyc = -1, valid_rise_cyc = -1, last_byte_cyc = -1, done_cyc = -1;
  logic       prev_stall = 1'b0, prev_arm = 1'b0, prev_valid = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    tog = ~tog;
    case (ready_mode)
      0:       bus.I_data_ready = 1'b1;
      1:       bus.I_data_ready = tog;
      2:       bus.I_data_ready = 1'($urandom_range(0, 1));
      default: bus.I_data_ready = 1'b0;
    endcase
    if (rst) begin
      prev_stall = 1'b0;
      prev_arm   = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (bus.O_fifo_rd_en) begin
        pop_cnt++;
        last_pop_cyc = cyc;
        if (bus.O_flushing) flush_pop_cnt++;
      end
      if (bus.O_fifo_rd_en && bus.I_fifo_empty) rd_empty_viol++;
      if (prev_stall && !prev_arm && (!bus.O_data_valid || bus.O_data !== prev_data)) stable_viol++;
      if ((prev_arm || bus.O_flushing) && bus.O_data_valid) abort_viol++;
      if (bus.O_data_valid && !prev_valid) valid_rise_cyc = cyc;
      if (bus.O_data_valid && bus.I_data_ready) begin
        got_q.push_back(bus.O_data);
        last_byte_cyc = cyc;
      end
      if (bus.O_burst_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = bus.O_data_valid && !bus.I_data_ready;
      prev_data  = bus.O_data;
      prev_arm   = bus.I_arm;
      prev_valid = bus.O_data_valid;
    end
  end

  // Reference model: expected byte stream for a run of entries under one status value.
  logic [7:0] exp_q[$];

  task automatic expect_entries(input int base, input int n, input logic [5:0] st);
    logic [17:0] d;
    for (int i = 0; i < n; i++) begin
      d = mem[base + i];
      exp_q.push_back(d[7:0]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back({st, d[17:16]});
    end
  endtask

  task automatic compare_bytes(input string tag, input int got_base);
    int n;
    n = got_q.size() - got_base;
    check($sformatf("%s_count", tag), n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[got_base + i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [17:0] d);
    mem[wr_idx] = d;
    wr_idx++;
  endtask

  task automatic pulse_arm();
    bus.I_arm = 1'b1;
    tick();
    bus.I_arm = 1'b0;
  endtask

  task automatic start_burst(input int len);
    bus.I_burst_len = LW'(len);
    bus.I_burst_req = 1'b1;
    tick();
    bus.I_burst_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.O_busy && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("%s_idle", tag), bus.O_busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gb, pb, db, fb, base, len, extra, first;
    logic [5:0] st;

    bus.I_arm = 1'b0;
    bus.I_burst_req = 1'b0;
    bus.I_burst_len = '0;
    bus.I_fifo_status = '0;
    repeat (3) tick();
    check("reset_outs", {bus.O_fifo_rd_en, bus.O_data, bus.O_data_valid, bus.O_busy,
                         bus.O_flushing, bus.O_burst_done, bus.O_timeout}, '0);

    // Zero-length burst requested right after reset release.
    rst = 1'b0;
    pb  = pop_cnt;
    start_burst(0);
    check("len0_done", bus.O_burst_done, 1'b1);
    tick();
    check("len0_done_once", bus.O_burst_done, 1'b0);
    check("len0_idle", bus.O_busy, 1'b0);
    check("len0_pops", pop_cnt - pb, 0);

    // Single entry, fixed pattern.
    ready_mode = 0;
    bus.I_fifo_status = 6'h15;
    push(18'h2A5A3);
    gb = got_q.size(); pb = pop_cnt; db = done_cnt;
    start_burst(1);
    wait_idle("single", 100);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h56);
    compare_bytes("single", gb);
    check("single_pops", pop_cnt - pb, 1);
    check("single_done", done_cnt - db, 1);
    check("single_latency", valid_rise_cyc - last_pop_cyc, 2);
    check("single_done_cyc", done_cyc - last_byte_cyc, 1);

    // Arm in IDLE flushes five entries.
    for (int i = 0; i < 5; i++) push(18'($urandom));
    gb = got_q.size(); pb = pop_cnt; fb = flush_pop_cnt;
    pulse_arm();
    wait_idle("flush5", 100);
    check("flush5_pops", pop_cnt - pb, 5);
    check("flush5_flush_pops", flush_pop_cnt - fb, 5);
    check("flush5_bytes", got_q.size() - gb, 0);
    check("flush5_drained", rd_idx, wr_idx);

    // Three entries with ready toggling every cycle.
    ready_mode = 1;
    st = 6'($urandom);
    bus.I_fifo_status = st;
    base = wr_idx;
    for (int i = 0; i < 3; i++) push(18'($urandom));
    gb = got_q.size(); pb = pop_cnt; db = done_cnt;
    start_burst(3);
    wait_idle("toggle", 200);
    expect_entries(base, 3, st);
    compare_bytes("toggle", gb);
    check("toggle_pops", pop_cnt - pb, 3);
    check("toggle_done", done_cnt - db, 1);

    // Random bursts with late-arriving entries and random sink back-pressure.
    for (int it = 0; it < 20; it++) begin
      len   = $urandom_range(1, 6);
      extra = $urandom_range(0, 2);
      first = $urandom_range(0, len);
      ready_mode = $urandom_range(0, 2);
      st = 6'($urandom);
      bus.I_fifo_status = st;
      base = wr_idx;
      for (int i = 0; i < first; i++) push(18'($urandom));
      gb = got_q.size(); pb = pop_cnt; db = done_cnt;
      start_burst(len);
      repeat ($urandom_range(0, 5)) tick();
      for (int i = first; i < len + extra; i++) push(18'($urandom));
      wait_idle($sformatf("rnd%0d", it), 400);
      expect_entries(base, len, st);
      compare_bytes($sformatf("rnd%0d", it), gb);
      check($sformatf("rnd%0d_pops", it), pop_cnt - pb, len);
      check($sformatf("rnd%0d_done", it), done_cnt - db, 1);
      if (extra > 0) begin
        pulse_arm();
        wait_idle($sformatf("rnd%0d_flush", it), 100);
        check($sformatf("rnd%0d_drained", it), rd_idx, wr_idx);
      end
    end

    // Abort with arm while the second entry's byte 1 is presented.
    ready_mode = 0;
    st = 6'($urandom);
    bus.I_fifo_status = st;
    base = wr_idx;
    for (int i = 0; i < 4; i++) push(18'($urandom));
    gb = got_q.size(); pb = pop_cnt; db = done_cnt; fb = flush_pop_cnt;
    start_burst(4);
    begin
      int n = 0;
      while ((got_q.size() - gb) < 4 && n < 200) begin
        tick();
        n++;
      end
    end
    check("abort_presented", bus.O_data_valid, 1'b1);
    ready_mode = 3;
    pulse_arm();
    wait_idle("abort", 100);
    expect_entries(base, 1, st);
    exp_q.push_back(mem[base + 1][7:0]);
    compare_bytes("abort", gb);
    check("abort_no_done", done_cnt - db, 0);
    check("abort_pops", pop_cnt - pb, 4);
    check("abort_flush_pops", flush_pop_cnt - fb, 2);
    check("abort_drained", rd_idx, wr_idx);
    ready_mode = 0;

    // Burst longer than the FIFO contents.
    st = 6'($urandom);
    bus.I_fifo_status = st;
    base = wr_idx;
    push(18'($urandom));
    gb = got_q.size(); db = done_cnt;
    start_burst(2);
`ifdef PW_BURST_TIMEOUT_EN
    wait_idle("tmo", 100);
    expect_entries(base, 1, st);
    compare_bytes("tmo", gb);
    check("tmo_flag", bus.O_timeout, 1'b1);
    check("tmo_done", done_cnt - db, 1);
    check("tmo_done_cyc", done_cyc - last_byte_cyc, TO + 1);
    pulse_arm();
    wait_idle("tmo_clear", 100);
    check("tmo_cleared", bus.O_timeout, 1'b0);
`else
    repeat (40) tick();
    check("stall_busy", bus.O_busy, 1'b1);
    check("stall_no_done", done_cnt - db, 0);
    check("stall_no_timeout", bus.O_timeout, 1'b0);
    expect_entries(base, 1, st);
    compare_bytes("stall", gb);
    pulse_arm();
    wait_idle("stall_abort", 100);
`endif

    // Reset asserted while a byte is held by a stalled sink.
    ready_mode = 3;
    push(18'($urandom));
    start_burst(1);
    begin
      int n = 0;
      while (!bus.O_data_valid && n < 50) begin
        tick();
        n++;
      end
    end
    check("rst_mid_valid", bus.O_data_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_outs", {bus.O_fifo_rd_en, bus.O_data, bus.O_data_valid, bus.O_busy,
                           bus.O_flushing, bus.O_burst_done, bus.O_timeout}, '0);
    tick();
    rst = 1'b0;
    ready_mode = 0;
    tick();
    check("rst_mid_idle", bus.O_busy, 1'b0);

    check("rd_en_on_empty", rd_empty_viol, 0);
    check("stable_while_stalled", stable_viol, 0);
    check("valid_after_abort", abort_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
